// File: rtl/pos_embd_pkg.sv
// rtl/pos_embd_pkg.sv - shared constants, types and FSM states for the positional-embedding sequencer
//
// Purpose : default geometry of the embedding ROM plus the position/length
//           typedefs and the sequencer state enum.
// Ports   : none (package).
package pos_embd_pkg;

   localparam int N_POS  = 16;
   localparam int N_EMBD = 8;
   localparam int POS_W  = $clog2(N_POS);
   localparam int LEN_W  = POS_W + 1;

   typedef logic [POS_W-1:0] pos_t;
   typedef logic [LEN_W-1:0] len_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/pos_embd_sequencer.sv
// rtl/pos_embd_sequencer.sv - streams positional-embedding vectors 0..seq_len-1 from an external ROM
//
// Purpose : on start, reads positions 0..eff_len-1 from a 1-cycle-latency ROM
//           and presents them as a valid/ready stream, one beat per cycle.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           start, seq_len      - sequence request (sampled only when idle)
//           busy, done          - activity flag, one-cycle completion pulse
//           rom_pos, rom_data   - ROM address (combinational) and read data
//           out_valid/out_ready - beat handshake
//           out_data, out_pos   - embedding vector and its position
//           out_last            - marks the final beat of the sequence
module pos_embd_sequencer #(
   parameter int N_POS  = pos_embd_pkg::N_POS,
   parameter int N_EMBD = pos_embd_pkg::N_EMBD
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(N_POS):0]     seq_len,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(N_POS)-1:0]   rom_pos,
   input  logic [N_EMBD*8-1:0]        rom_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_EMBD*8-1:0]        out_data,
   output logic [$clog2(N_POS)-1:0]   out_pos,
   output logic                       out_last
);

   import pos_embd_pkg::*;

   localparam int PW = $clog2(N_POS);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] N_POS_L = LW'(N_POS);

   state_t          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   eff_len;
   logic            at_last;
   logic            handshake;

   // Oversized requests are silently clamped to the ROM depth.
   assign eff_len   = (seq_len > N_POS_L) ? N_POS_L : seq_len;
   assign at_last   = ({1'b0, pos_q} == (len_q - 1'b1));
   assign handshake = (state_q == ST_STREAM) && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pos_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      len_d   = len_q;
      rom_pos = pos_q;
      case (state_q)
         ST_IDLE: begin
            // Address 0 is pre-read so beat 0 is ready the cycle after start.
            rom_pos = '0;
            if (start) begin
               len_d   = eff_len;
               pos_d   = '0;
               state_d = (eff_len == '0) ? ST_DONE : ST_STREAM;
            end
         end
         ST_STREAM: begin
            // On a handshake the ROM fetches the next beat; otherwise it
            // re-reads the held position so out_data stays stable.  The last
            // beat keeps the address on pos instead of stepping past the end.
            if (handshake) begin
               if (at_last) begin
                  state_d = ST_DONE;
               end else begin
                  pos_d   = pos_q + 1'b1;
                  rom_pos = pos_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            pos_d   = '0;
            len_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            pos_d   = '0;
            len_d   = '0;
         end
      endcase
   end

   assign out_valid = (state_q == ST_STREAM);
   assign out_last  = out_valid && at_last;
   assign out_pos   = pos_q;
   assign out_data  = rom_data;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pos_embd_sequencer.sv
// tb/tb_pos_embd_sequencer.sv - self-checking bench for pos_embd_sequencer
module tb_pos_embd_sequencer;

   import pos_embd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   len_t        seq_len;
   logic        busy, done;
   pos_t        rom_pos;
   logic [63:0] rom_data;
   logic        out_valid, out_ready;
   logic [63:0] out_data;
   pos_t        out_pos;
   logic        out_last;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int          mq[$];
   bit          m_done = 1'b0;

   int          hs_pos[$];
   int          hs_cyc[$];
   logic [63:0] hs_data[$];
   logic        hs_last[$];
   int          done_count = 0;
   int          done_cyc   = -1;

   pos_embd_sequencer #(.N_POS(16), .N_EMBD(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seq_len   (seq_len),
      .busy      (busy),
      .done      (done),
      .rom_pos   (rom_pos),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_pos   (out_pos),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] word(input int p);
      logic [63:0] w;
      for (int e = 0; e < 8; e++) w[8*e +: 8] = 8'(8*p + e);
      return w;
   endfunction

   // ROM contents: element e of position p is 8p+e, one-cycle read latency.
   always @(posedge clk) rom_data <= word(int'(rom_pos));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a queue of positions still to be delivered plus a
   // pending-done flag, advanced from the inputs that the next edge samples.
   always @(negedge clk) begin
      bit was_done;
      int eff;
      if (rst) begin
         mq.delete();
         m_done = 1'b0;
      end
      check("valid", out_valid, mq.size() > 0);
      check("busy",  busy, (mq.size() > 0) || m_done);
      check("done",  done, m_done);
      if (mq.size() > 0) begin
         check("pos",  out_pos, mq[0]);
         check("data", out_data, word(mq[0]));
         check("last", out_last, mq.size() == 1);
         if (!out_ready)
            check("rom_hold", rom_pos, mq[0]);
         else if (mq.size() > 1)
            check("rom_next", rom_pos, mq[0] + 1);
      end else begin
         check("last_idle", out_last, 1'b0);
         if (!m_done) check("rom_idle", rom_pos, 0);
      end

      if (out_valid && out_ready) begin
         hs_pos.push_back(int'(out_pos));
         hs_cyc.push_back(cyc);
         hs_data.push_back(out_data);
         hs_last.push_back(out_last);
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end

      if (!rst) begin
         was_done = m_done;
         m_done   = 1'b0;
         if (mq.size() > 0) begin
            if (out_ready) begin
               void'(mq.pop_front());
               if (mq.size() == 0) m_done = 1'b1;
            end
         end else if (!was_done && start) begin
            eff = (int'(seq_len) > 16) ? 16 : int'(seq_len);
            for (int i = 0; i < eff; i++) mq.push_back(i);
            if (eff == 0) m_done = 1'b1;
         end
      end
   end

   task automatic clear_logs();
      hs_pos.delete();
      hs_cyc.delete();
      hs_data.delete();
      hs_last.delete();
      done_cyc = -1;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_count;
      int n  = 0;
      while (done_count == d0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_count == d0) check("done_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      int t;
      int d0;
      rst = 1'b1; start = 1'b0; seq_len = '0; out_ready = 1'b0;
      #2;
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy",  busy, 1'b0);
      check("rst_done",  done, 1'b0);
      check("rst_last",  out_last, 1'b0);
      check("rst_rompos", rom_pos, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);

      // Full-rate stream of 4 beats.
      #1; out_ready = 1'b1; start = 1'b1; seq_len = 5'd4; t = cyc; clear_logs();
      @(posedge clk); #1 start = 1'b0;
      wait_done(20);
      check("t1_beats", hs_pos.size(), 4);
      check("t1_first_cyc", hs_cyc[0], t + 1);
      check("t1_last_cyc", hs_cyc[3], t + 4);
      check("t1_last_flag", hs_last[3], 1'b1);
      check("t1_notlast", hs_last[2], 1'b0);
      check("t1_data2", hs_data[2], 64'h1716151413121110);
      check("t1_done_cyc", done_cyc, t + 5);

      // Backpressure on beat 1 for three cycles.
      @(posedge clk); #1; start = 1'b1; seq_len = 5'd3; t = cyc; clear_logs();
      @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done(20);
      check("t2_beats", hs_pos.size(), 3);
      check("t2_pos1", hs_pos[1], 1);
      check("t2_pos2", hs_pos[2], 2);
      check("t2_data1", hs_data[1], 64'h0F0E0D0C0B0A0908);
      check("t2_beat1_cyc", hs_cyc[1], t + 5);

      // Zero length: done without any beat.
      @(posedge clk); #1; start = 1'b1; seq_len = 5'd0; t = cyc; clear_logs();
      @(posedge clk); #1 start = 1'b0;
      wait_done(5);
      check("t3_beats", hs_pos.size(), 0);
      check("t3_done_cyc", done_cyc, t + 1);

      // Oversized length is clamped to 16.
      @(posedge clk); #1; start = 1'b1; seq_len = 5'd20; clear_logs();
      @(posedge clk); #1 start = 1'b0;
      wait_done(40);
      check("t4_beats", hs_pos.size(), 16);
      check("t4_last_pos", hs_pos[15], 15);
      check("t4_last_flag", hs_last[15], 1'b1);

      // start during STREAM is ignored.
      @(posedge clk); #1; start = 1'b1; seq_len = 5'd5; clear_logs(); d0 = done_count;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1; seq_len = 5'd3;
      @(posedge clk); #1 start = 1'b0;
      wait_done(20);
      repeat (6) @(posedge clk);
      #1;
      check("t5_beats", hs_pos.size(), 5);
      check("t5_done_pulses", done_count - d0, 1);

      // Reset in the middle of a sequence.
      @(posedge clk); #1; start = 1'b1; seq_len = 5'd8; clear_logs(); d0 = done_count;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t6_beats_before", hs_pos.size(), 3);
      check("t6_rst_valid", out_valid, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_last", out_last, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b1; seq_len = 5'd2; t = cyc;
      check("t6_no_done", done_count - d0, 0);
      clear_logs();
      @(posedge clk); #1 start = 1'b0;
      wait_done(10);
      check("t6_beats", hs_pos.size(), 2);
      check("t6_pos0", hs_pos[0], 0);
      check("t6_pos1", hs_pos[1], 1);
      check("t6_first_cyc", hs_cyc[0], t + 1);
      check("t6_done_pulses", done_count - d0, 1);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/pos_embd_sequencer.md
POS_EMBD_SEQUENCER -- requirements
Module: pos_embd_sequencer

Interface
REQ-001 Parameter N_POS, default 16, number of positions held in the positional-embedding ROM.
REQ-002 Parameter N_EMBD, default 8, number of 8-bit elements per embedding vector.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to stream positions 0..seq_len-1; sampled only in IDLE.
REQ-006 seq_len  input  $clog2(N_POS)+1  number of positions to stream; sampled with start.
REQ-007 busy  output  1  high in STREAM and DONE.
REQ-008 done  output  1  one-cycle pulse after the final beat is accepted.
REQ-009 rom_pos  output  $clog2(N_POS)  combinational address to the external 1-cycle-latency embedding ROM.
REQ-010 rom_data  input  N_EMBD*8  ROM read data, element e at bits [8e+7:8e].
REQ-011 out_valid  output  1  embedding beat available.
REQ-012 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-013 out_data  output  N_EMBD*8  pass-through of rom_data.
REQ-014 out_pos  output  $clog2(N_POS)  position index of the current beat.
REQ-015 out_last  output  1  high with the final beat of a sequence.

Function
REQ-016 FSM states: IDLE, STREAM and DONE only; at most one sequence is in progress.
REQ-017 IDLE: rom_pos = 0 and out_valid = 0; start=1 with eff_len>0 -> STREAM, and start=1 with eff_len=0 -> DONE.
REQ-018 eff_len = min(seq_len, N_POS); any seq_len above N_POS is clamped with no error.
REQ-019 Latency: start accepted in cycle t -> out_valid=1 in cycle t+1 with out_pos=0 and out_data=ROM[0].
REQ-020 STREAM: out_valid=1 continuously; pos register = current beat index; out_pos = pos.
REQ-021 rom_pos = pos+1 in a handshake cycle and pos otherwise, so that the ROM re-reads the held position while stalled.
REQ-022 Throughput: one beat per cycle while out_ready is held high, with no bubbles between beats.
REQ-023 Stall: while out_ready=0, out_valid, out_pos, out_data and out_last remain stable.
REQ-024 out_last = 1 exactly when pos = eff_len-1 in STREAM.
REQ-025 Handshake on the last beat -> DONE in the next cycle, with out_valid=0.
REQ-026 DONE lasts exactly one cycle with done=1, then goes to IDLE.
REQ-027 start asserted in STREAM or DONE is ignored and is not queued.
REQ-028 pos never exceeds N_POS-1, and rom_pos never wraps past eff_len-1 into a live read.

Reset
REQ-029 rst asserted -> state=IDLE, pos=0, latched length=0, out_valid=0, out_last=0, busy=0 and done=0, all immediately and without waiting for clk.
REQ-030 Reset mid-sequence discards the sequence; no done pulse is produced for it.
REQ-031 The first start is accepted in the first clk cycle after rst deasserts.

Structure
REQ-032 Shared package pos_embd_pkg holds N_POS, N_EMBD, the pos_t / len_t typedefs and the state enum.
REQ-033 No sub-module: the FSM and counter are inline, and the ROM is instantiated by the parent and connected through rom_pos/rom_data.

Verification
REQ-034 Full-rate stream: start, seq_len=4, out_ready=1 -> beats pos 0,1,2,3 in cycles t+1..t+4 with data element e = 8p+e; out_last in cycle t+4; done in cycle t+5.
REQ-035 Backpressure: seq_len=3, out_ready=0 for 3 cycles on beat 1 -> beat 1 held stable with data bytes 8..15; sequence completes with no lost or duplicated beat.
REQ-036 Boundaries: seq_len=0 -> done in cycle t+1 with no out_valid; seq_len=20 with N_POS=16 -> 16 beats, last out_pos=15.
REQ-037 start pulsed during STREAM -> ignored; exactly seq_len beats and one done pulse.
REQ-038 rst asserted after beat 2 of seq_len=8 -> out_valid=0 immediately, no done; new start with seq_len=2 -> beats 0,1 and done.
